// File: rtl/tt_uart_tx.sv
// tt_uart_tx: 8N1 serial transmitter, LSB first, fed by a small byte FIFO.
// Latency: a byte written at edge N into an empty FIFO while idle and enabled drives the start bit from edge N+1.
// Backpressure: wr_ready = FIFO not full; while it is low the writer holds wr_valid/wr_data and no push occurs.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   ena                 low blocks new frames; a frame already on the line completes
//   wr_data/wr_valid    byte offered by the writer; stored when wr_valid && wr_ready
//   wr_ready            FIFO not full
//   tx                  serial line, idle high, driven straight from a flop
//   busy                frame on the line or FIFO non-empty
//   level               FIFO occupancy 0..FIFO_DEPTH
module tt_uart_tx #(
    parameter int CLK_DIV    = 87,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE    = 1;
    localparam logic [15:0] DIV_RELOAD = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    // FIFO storage and pointers; the extra pointer MSB tells full from empty.
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [7:0]  head;

    // Transmit engine state.
    state_e      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Push depends only on the registered full flag, so a pop on the same
    // edge never frees a slot for the writer early.
    assign push  = wr_valid && !full;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    assign rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    assign wr_ready = !full;
    assign level    = wr_ptr_q - rd_ptr_q;
    assign busy     = (state_q != IDLE) || (level != '0);
    assign tx       = tx_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty && ena) begin
                    pop     = 1'b1;
                    shift_d = head;
                    div_d   = DIV_RELOAD;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end

            START: begin
                if (div_q == 16'd0) begin
                    div_d   = DIV_RELOAD;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    div_d = div_q - 16'd1;
                end
            end

            DATA: begin
                if (div_q == 16'd0) begin
                    div_d = DIV_RELOAD;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Next bit is shift_q[1]; presenting it now keeps tx a pure flop.
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    div_d = div_q - 16'd1;
                end
            end

            STOP: begin
                if (div_q == 16'd0) begin
                    if (!empty && ena) begin
                        // Chain straight into the next start bit: no idle gap.
                        pop     = 1'b1;
                        shift_d = head;
                        div_d   = DIV_RELOAD;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    div_d = div_q - 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= IDLE;
            div_q    <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_tt_uart_tx.sv
// Bench for tt_uart_tx: a 4-deep and a 2-deep instance, both CLK_DIV = 4.
// Written bytes are pushed to a scoreboard queue on acceptance; a line receiver
// decodes frames at mid-bit and pops/compares them.
module tb_tt_uart_tx;

    localparam int DIV   = 4;
    localparam int FRAME = 10 * DIV;
    localparam int PER   = 10;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       ena, wr_valid, wr_ready, tx, busy;
    logic [7:0] wr_data;
    logic [2:0] level;

    logic       ena2, wr_valid2, wr_ready2, tx2, busy2;
    logic [7:0] wr_data2;
    logic [1:0] level2;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_q2[$];

    always #(PER/2) clk = ~clk;

    tt_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .tx(tx), .busy(busy), .level(level)
    );

    tt_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena2), .wr_data(wr_data2), .wr_valid(wr_valid2),
        .wr_ready(wr_ready2), .tx(tx2), .busy(busy2), .level(level2)
    );

    function automatic logic line(input int which);
        return (which == 1) ? tx2 : tx1_sel();
    endfunction

    function automatic logic tx1_sel();
        return tx;
    endfunction

    // Waits (bounded) for a start bit, then samples every bit 2.5 cycles into its slot.
    task automatic rx_byte(input int which, output logic [7:0] b, output logic stop_bit,
                           output time t_start, output bit timed_out);
        int guard;
        guard     = 0;
        b         = 8'h00;
        stop_bit  = 1'b0;
        t_start   = 0;
        timed_out = 1'b0;
        @(negedge clk);
        while (line(which) !== 1'b0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 400) begin
            timed_out = 1'b1;
            return;
        end
        t_start = $time;
        repeat (DIV/2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            repeat (DIV) @(negedge clk);
            b[k] = line(which);
        end
        repeat (DIV) @(negedge clk);
        stop_bit = line(which);
    endtask

    task automatic test_reset();
        logic [5:0] obs, want;
        rst_n = 1'b1;
        ena = 1'b1; wr_valid = 1'b0; wr_data = 8'h00;
        ena2 = 1'b1; wr_valid2 = 1'b0; wr_data2 = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        want = {1'b1, 1'b0, 1'b1, 3'd0};
        obs  = {tx, busy, wr_ready, level};
        n_checks++;
        if (obs !== want) $display("FAIL reset_held: got %b expected %b", obs, want);
        else n_pass++;
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            obs = {tx, busy, wr_ready, level};
            n_checks++;
            if (obs !== want) $display("FAIL idle_cycle%0d: got %b expected %b", c, obs, want);
            else n_pass++;
        end
    endtask

    task automatic test_single_a5();
        logic [9:0] exp_bits;
        exp_bits = 10'b11_0100_1010;   // start, 0xA5 LSB first, stop
        @(negedge clk);
        wr_valid = 1'b1; wr_data = 8'hA5;
        @(posedge clk);                 // edge N: accepted
        @(negedge clk);
        wr_valid = 1'b0;
        n_checks++;
        if ({tx, level} !== {1'b1, 3'd1}) $display("FAIL a5_after_write: got tx/level %b/%0d expected 1/1", tx, level);
        else n_pass++;
        @(negedge clk);                 // after edge N+1
        n_checks++;
        if ({tx, level, busy} !== {1'b0, 3'd0, 1'b1}) $display("FAIL a5_start_edge: got tx/level/busy %b/%0d/%b expected 0/0/1", tx, level, busy);
        else n_pass++;
        repeat (DIV/2) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) repeat (DIV) @(negedge clk);
            n_checks++;
            if (tx !== exp_bits[k]) $display("FAIL a5_bit%0d: got %b expected %b", k, tx, exp_bits[k]);
            else n_pass++;
        end
        @(negedge clk);                 // start edge + 39.5
        n_checks++;
        if (busy !== 1'b1) $display("FAIL a5_busy_last: got %b expected 1", busy);
        else n_pass++;
        @(negedge clk);                 // start edge + 40.5
        n_checks++;
        if ({busy, tx} !== 2'b01) $display("FAIL a5_busy_end: got busy/tx %b/%b expected 0/1", busy, tx);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [5];
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C; bytes[3] = 8'h81; bytes[4] = 8'h55;
        exp_q.delete();
        // Hold off transmission so the FIFO fills before the first pop.
        ena = 1'b0;
        fork
            begin : writer
                int i, guard;
                i = 0; guard = 0;
                @(negedge clk);
                while (i < 5 && guard < 100) begin
                    guard++;
                    wr_valid = 1'b1; wr_data = bytes[i];
                    if (wr_ready) begin
                        @(posedge clk);
                        exp_q.push_back(bytes[i]);
                        i++;
                        @(negedge clk);
                    end else begin
                        n_checks++;
                        if ({i, level} !== {32'd4, 3'd4}) $display("FAIL b2b_full: got accepts/level %0d/%0d expected 4/4", i, level);
                        else n_pass++;
                        ena = 1'b1;
                        @(posedge clk);
                        @(negedge clk);
                        n_checks++;
                        if ({wr_ready, level} !== {1'b1, 3'd3}) $display("FAIL b2b_ready_rise: got ready/level %b/%0d expected 1/3", wr_ready, level);
                        else n_pass++;
                    end
                end
                wr_valid = 1'b0;
                n_checks++;
                if (i !== 5) $display("FAIL b2b_writes: got %0d accepted expected 5", i);
                else n_pass++;
            end
            begin : receiver
                logic [7:0] b, e;
                logic sb;
                time t, t_prev, t_first;
                bit to;
                t_prev = 0; t_first = 0;
                for (int k = 0; k < 5; k++) begin
                    rx_byte(0, b, sb, t, to);
                    if (to) begin
                        n_checks++;
                        $display("FAIL b2b_timeout: got no start bit for frame %0d expected one", k);
                        break;
                    end
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                    n_checks++;
                    if ({b, sb} !== {e, 1'b1}) $display("FAIL b2b_frame%0d: got %h stop %b expected %h stop 1", k, b, sb, e);
                    else n_pass++;
                    if (k == 0) t_first = t;
                    else begin
                        n_checks++;
                        if ((t - t_prev) !== FRAME * PER) $display("FAIL b2b_gap%0d: got %0t expected %0d", k, t - t_prev, FRAME * PER);
                        else n_pass++;
                    end
                    t_prev = t;
                end
                n_checks++;
                if ((t_prev - t_first) !== 4 * FRAME * PER) $display("FAIL b2b_span: got %0t expected %0d", t_prev - t_first, 4 * FRAME * PER);
                else n_pass++;
                repeat (2) @(negedge clk);
                n_checks++;
                if ({busy, tx} !== 2'b01) $display("FAIL b2b_busy_end: got busy/tx %b/%b expected 0/1", busy, tx);
                else n_pass++;
            end
        join
    endtask

    task automatic test_ena();
        logic [7:0] b, e;
        logic sb;
        time t;
        bit to, stayed;
        exp_q.delete();
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wr_valid = 1'b1; wr_data = 8'h11 * 8'(k + 1) + 8'h40;
            @(posedge clk);
            exp_q.push_back(wr_data);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        stayed = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (tx !== 1'b1) stayed = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if ({stayed, level} !== {1'b1, 3'd3}) $display("FAIL ena_hold: got tx_high/level %b/%0d expected 1/3", stayed, level);
        else n_pass++;
        ena = 1'b1;
        fork
            begin
                repeat (60) @(negedge clk);   // lands inside the second frame
                ena = 1'b0;
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    rx_byte(0, b, sb, t, to);
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                    n_checks++;
                    if (to || {b, sb} !== {e, 1'b1}) $display("FAIL ena_frame%0d: got %h stop %b timeout %b expected %h stop 1", k, b, sb, to, e);
                    else n_pass++;
                end
            end
        join
        stayed = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (tx !== 1'b1) stayed = 1'b0;
        end
        n_checks++;
        if ({stayed, level, busy} !== {1'b1, 3'd1, 1'b1}) $display("FAIL ena_held: got tx_high/level/busy %b/%0d/%b expected 1/1/1", stayed, level, busy);
        else n_pass++;
        ena = 1'b1;
        rx_byte(0, b, sb, t, to);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++;
        if (to || {b, sb} !== {e, 1'b1}) $display("FAIL ena_frame2: got %h stop %b timeout %b expected %h stop 1", b, sb, to, e);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, level} !== {1'b0, 3'd0}) $display("FAIL ena_drained: got busy/level %b/%0d expected 0/0", busy, level);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        bit quiet;
        exp_q.delete();
        ena = 1'b1;
        @(negedge clk);
        wr_valid = 1'b1; wr_data = 8'hF0;
        @(posedge clk);                 // edge E; start edge S = E+1
        @(negedge clk);
        wr_data = 8'h12;
        @(posedge clk);
        @(negedge clk);
        wr_data = 8'h34;
        @(posedge clk);
        @(negedge clk);                 // S + 1.5
        wr_valid = 1'b0;
        repeat (21) @(negedge clk);     // S + 22.5: middle of data bit 4
        n_checks++;
        if ({tx, level, busy} !== {1'b1, 3'd2, 1'b1}) $display("FAIL rst_pre: got tx/level/busy %b/%0d/%b expected 1/2/1", tx, level, busy);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx, level, busy, wr_ready} !== {1'b1, 3'd0, 1'b0, 1'b1}) $display("FAIL rst_async: got tx/level/busy/ready %b/%0d/%b/%b expected 1/0/0/1", tx, level, busy, wr_ready);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (quiet !== 1'b1) $display("FAIL rst_quiet: got quiet %b expected 1", quiet);
        else n_pass++;
    endtask

    task automatic test_depth2_push_pop();
        exp_q2.delete();
        ena2 = 1'b1;
        fork
            begin : driver
                @(negedge clk);
                wr_valid2 = 1'b1; wr_data2 = 8'h6B;
                @(posedge clk);             // edge E; first start edge S1 = E+1
                exp_q2.push_back(8'h6B);
                @(negedge clk);
                wr_valid2 = 1'b0;
                repeat (5) @(negedge clk);
                wr_valid2 = 1'b1; wr_data2 = 8'hC4;
                @(posedge clk);
                exp_q2.push_back(8'hC4);
                @(negedge clk);             // E + 6.5
                wr_valid2 = 1'b0;
                repeat (34) @(negedge clk); // S1 + 39.5: last cycle of the stop bit
                n_checks++;
                if ({level2, tx2, wr_ready2} !== {2'd1, 1'b1, 1'b1}) $display("FAIL d2_pre: got level/tx/ready %0d/%b/%b expected 1/1/1", level2, tx2, wr_ready2);
                else n_pass++;
                wr_valid2 = 1'b1; wr_data2 = 8'h2D;
                @(posedge clk);             // push and STOP->START pop together
                exp_q2.push_back(8'h2D);
                @(negedge clk);
                wr_valid2 = 1'b0;
                n_checks++;
                if ({level2, tx2} !== {2'd1, 1'b0}) $display("FAIL d2_push_pop: got level/tx %0d/%b expected 1/0", level2, tx2);
                else n_pass++;
            end
            begin : receiver
                logic [7:0] b, e;
                logic sb;
                time t, t_prev;
                bit to;
                t_prev = 0;
                for (int k = 0; k < 3; k++) begin
                    rx_byte(1, b, sb, t, to);
                    e = (exp_q2.size() != 0) ? exp_q2.pop_front() : 8'hxx;
                    n_checks++;
                    if (to || {b, sb} !== {e, 1'b1}) $display("FAIL d2_frame%0d: got %h stop %b timeout %b expected %h stop 1", k, b, sb, to, e);
                    else n_pass++;
                    if (k == 1) begin
                        n_checks++;
                        if ((t - t_prev) !== FRAME * PER) $display("FAIL d2_gap: got %0t expected %0d", t - t_prev, FRAME * PER);
                        else n_pass++;
                    end
                    t_prev = t;
                end
            end
        join
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy2, level2} !== {1'b0, 2'd0}) $display("FAIL d2_drained: got busy/level %b/%0d expected 0/0", busy2, level2);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_ena();
        test_reset_midframe();
        test_depth2_push_pop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time bound so a stuck run still reports.
    initial begin
        #(PER * 20000);
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
